hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/riscv_pkg.sv | 17 +
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/fwd_unit.sv | 23 ++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline-control types: hazard FSM state encoding and ALU operand
// forward-select codes used by the hazard unit and the execute datapath.
package riscv_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    IWAIT  = 2'd1,
    IFLUSH = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard-unit signal bundle: register tags and stage status in,
// stage enables/clears, forward selects and status counters out.
interface hazard_ctrl_if;
  import riscv_pkg::*;

  logic [REG_AW-1:0] Rs1D, Rs2D;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
  logic [REG_AW-1:0] RdM, RdW;
  logic              RegWriteM, RegWriteW;
  logic              LoadE;
  logic              PCSrcE;
  logic              imem_ready;
  logic              dmem_req_M, dmem_ready;

  logic              EnableF, EnableD, EnableBack;
  logic              ClearD, ClearE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              err_timeout;
  logic [31:0]       stall_cnt, flush_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           LoadE, PCSrcE, imem_ready, dmem_req_M, dmem_ready,
    input  EnableF, EnableD, EnableBack, ClearD, ClearE,
           ForwardAE, ForwardBE, err_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           LoadE, PCSrcE, imem_ready, dmem_req_M, dmem_ready,
    output EnableF, EnableD, EnableBack, ClearD, ClearE,
           ForwardAE, ForwardBE, err_timeout, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/fwd_unit.sv
// Operand forward select for one execute-stage source register; the memory
// stage result is newer than writeback and so takes precedence.
module fwd_unit
  import riscv_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              regwrite_m_i,
  input  logic              regwrite_w_i,
  output logic [1:0]        fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (regwrite_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
      fwd_o = FWD_MEM;
    end else if (regwrite_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush,
// instruction-fetch wait/flush FSM, data-memory freeze with timeout, counters.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 255
)(
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  localparam logic [31:0] TIMEOUT_U = TIMEOUT;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  hz_state_e   state_q, state_d;
  logic [7:0]  dwait_cnt_q, dwait_cnt_d;
  logic        err_q, err_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic freeze, lw_stall, fetch_bubble;
  logic en_f, en_d, en_back, clr_d, clr_e;

  fwd_unit u_fwd_a (
    .rs_i         (hz.Rs1E),
    .rd_m_i       (hz.RdM),
    .rd_w_i       (hz.RdW),
    .regwrite_m_i (hz.RegWriteM),
    .regwrite_w_i (hz.RegWriteW),
    .fwd_o        (hz.ForwardAE)
  );

  fwd_unit u_fwd_b (
    .rs_i         (hz.Rs2E),
    .rd_m_i       (hz.RdM),
    .rd_w_i       (hz.RdW),
    .regwrite_m_i (hz.RegWriteM),
    .regwrite_w_i (hz.RegWriteW),
    .fwd_o        (hz.ForwardBE)
  );

  assign freeze       = hz.dmem_req_M && !hz.dmem_ready;
  assign lw_stall     = hz.LoadE && (hz.RdE != '0) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign fetch_bubble = !hz.imem_ready || (state_q == IFLUSH);

  // Stage control; reset is folded in so the pipeline sees plain run
  // enables while reset is held, independent of the registered state.
  always_comb begin
    en_f    = 1'b1;
    en_d    = 1'b1;
    en_back = 1'b1;
    clr_d   = 1'b0;
    clr_e   = 1'b0;
    if (!reset) begin
      en_f = 1'b1;
    end else if (freeze) begin
      en_f    = 1'b0;
      en_d    = 1'b0;
      en_back = 1'b0;
    end else if (hz.PCSrcE) begin
      clr_d = 1'b1;
      clr_e = 1'b1;
    end else if (lw_stall) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      clr_e = 1'b1;
    end else if (fetch_bubble) begin
      clr_d = 1'b1;
      en_f  = hz.imem_ready;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!freeze) begin
      case (state_q)
        RUN: begin
          if (!hz.imem_ready) state_d = hz.PCSrcE ? IFLUSH : IWAIT;
        end
        IWAIT: begin
          // A redirect that coincides with the returning fetch is handled
          // by the normal flush, so only a redirect while still waiting
          // needs the extra discard.
          if (hz.PCSrcE && !hz.imem_ready) state_d = IFLUSH;
          else if (hz.imem_ready)          state_d = RUN;
        end
        IFLUSH: begin
          if (hz.imem_ready && !lw_stall) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    dwait_cnt_d = freeze ? sat_inc8(dwait_cnt_q) : 8'd0;
    err_d       = err_q || (freeze && ({24'd0, dwait_cnt_d} == TIMEOUT_U));
    stall_cnt_d = en_f ? stall_cnt_q : stall_cnt_q + 32'd1;
    flush_cnt_d = (hz.PCSrcE && !freeze) ? flush_cnt_q + 32'd1 : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      dwait_cnt_q <= 8'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      dwait_cnt_q <= dwait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.EnableF     = en_f;
  assign hz.EnableD     = en_d;
  assign hz.EnableBack  = en_back;
  assign hz.ClearD      = clr_d;
  assign hz.ClearE      = clr_e;
  assign hz.err_timeout = err_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule
